// File: rtl/uart_rx.sv
// 8N1 UART receiver using 16x oversampling strobes; mid-bit sampling with start-glitch rejection.
// Received bytes are held with a sticky ready flag plus an overrun flag, both cleared by the consumer.
module uart_rx (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic       r_rxMeta;
  logic       r_rxS;
  logic [3:0] r_sample;
  logic [3:0] w_sampleNext;
  logic [2:0] r_bitIdx;
  logic [2:0] w_bitIdxNext;
  logic [7:0] r_scratch;
  logic [7:0] w_scratchNext;
  logic [7:0] r_data;
  logic [7:0] w_dataNext;
  logic       r_rdy;
  logic       w_rdyNext;
  logic       r_frameErr;
  logic       w_frameErrNext;
  logic       r_overrun;
  logic       w_overrunNext;
  logic       w_byteDone;

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxS    <= r_rxMeta;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sample   <= 4'd0;
      r_bitIdx   <= 3'd0;
      r_scratch  <= 8'h00;
      r_data     <= 8'h00;
      r_rdy      <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_sample   <= w_sampleNext;
      r_bitIdx   <= w_bitIdxNext;
      r_scratch  <= w_scratchNext;
      r_data     <= w_dataNext;
      r_rdy      <= w_rdyNext;
      r_frameErr <= w_frameErrNext;
      r_overrun  <= w_overrunNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_sampleNext   = r_sample;
    w_bitIdxNext   = r_bitIdx;
    w_scratchNext  = r_scratch;
    w_dataNext     = r_data;
    w_rdyNext      = r_rdy;
    w_overrunNext  = r_overrun;
    w_frameErrNext = 1'b0;
    w_byteDone     = 1'b0;

    if (clken) begin
      case (r_state)
        IDLE: begin
          if (!r_rxS) begin
            w_stateNext  = START;
            w_sampleNext = 4'd1;
          end
        end
        // A start bit must stay low for eight ticks to be accepted.
        START: begin
          if (r_rxS) begin
            w_stateNext  = IDLE;
            w_sampleNext = 4'd0;
          end else if (r_sample == 4'd7) begin
            w_stateNext  = DATA;
            w_sampleNext = 4'd0;
            w_bitIdxNext = 3'd0;
          end else begin
            w_sampleNext = r_sample + 4'd1;
          end
        end
        DATA: begin
          if (r_sample == 4'd15) begin
            w_scratchNext[r_bitIdx] = r_rxS;
            w_sampleNext            = 4'd0;
            if (r_bitIdx == 3'd7) begin
              w_stateNext = STOP;
            end else begin
              w_bitIdxNext = r_bitIdx + 3'd1;
            end
          end else begin
            w_sampleNext = r_sample + 4'd1;
          end
        end
        // Leaving at mid-stop-bit lets a following start edge be caught without delay.
        STOP: begin
          if (r_sample == 4'd15) begin
            w_stateNext  = IDLE;
            w_sampleNext = 4'd0;
            if (r_rxS) begin
              w_byteDone = 1'b1;
            end else begin
              w_frameErrNext = 1'b1;
            end
          end else begin
            w_sampleNext = r_sample + 4'd1;
          end
        end
        default: begin
          w_stateNext  = IDLE;
          w_sampleNext = 4'd0;
        end
      endcase
    end

    if (rdy_clr) begin
      w_rdyNext     = 1'b0;
      w_overrunNext = 1'b0;
    end
    // A completing byte overrides a simultaneous acknowledge.
    if (w_byteDone) begin
      w_dataNext    = r_scratch;
      w_rdyNext     = 1'b1;
      w_overrunNext = r_rdy | r_overrun;
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of 8N1 frames with expected outputs,
// plus hand-written glitch, clear/set collision and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       clken;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int errors     = 0;
  int checks     = 0;
  int feCount    = 0;
  int feRun      = 0;
  int feMaxRun   = 0;
  int clkenPhase = 0;

  typedef struct {
    logic [7:0] value;
    logic       stopVal;
    logic       glitch;
    logic       clrBefore;
    logic       clrAtDone;
    logic [7:0] expData;
    logic       expRdy;
    logic       expOvr;
    int         expFe;
  } vec_t;

  vec_t vecs[6];

  uart_rx dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .clken    (clken),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial forever #10 clk_50m = ~clk_50m;

  // One-cycle clken strobe every 27 clocks, changing 1 ns after the edge.
  initial begin
    clken = 1'b0;
    forever begin
      @(posedge clk_50m);
      #1;
      clken      = (clkenPhase == 26);
      clkenPhase = (clkenPhase == 26) ? 0 : clkenPhase + 1;
    end
  end

  // Counts frame_err pulses and the longest run of consecutive high cycles.
  always @(negedge clk_50m) begin
    if (frame_err === 1'b1) begin
      feCount++;
      feRun++;
      if (feRun > feMaxRun) feMaxRun = feRun;
    end else begin
      feRun = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_50m);
    #2;
  endtask

  // Returns 2 ns after the edge that samples clken=1, so the next tick is 27 cycles away.
  task automatic alignToTick();
    int guard = 0;
    do begin
      waitCycles(1);
      guard++;
    end while (clken !== 1'b1 && guard < 100);
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL align: clken strobe not seen within 100 cycles");
    end
    waitCycles(1);
  endtask

  task automatic clearAndCheck(input string tag);
    rdy_clr = 1'b1;
    waitCycles(1);
    rdy_clr = 1'b0;
    checkOutput({tag, "_clr_rdy"}, {7'd0, rdy}, 8'h00);
    checkOutput({tag, "_clr_ovr"}, {7'd0, overrun}, 8'h00);
  endtask

  // Line goes low at cycle A; stop bit is sampled on the clken edge at A+4104.
  task automatic sendFrame(input logic [7:0] value, input logic stopVal, input int stopLen,
                           input logic clrAtDone);
    alignToTick();
    rx = 1'b0;
    waitCycles(432);
    for (int i = 0; i < 8; i++) begin
      rx = value[i];
      waitCycles(432);
    end
    rx = stopVal;
    if (clrAtDone) begin
      waitCycles(215);
      rdy_clr = 1'b1;
      waitCycles(1);
      rdy_clr = 1'b0;
      waitCycles(216);
    end else if (stopLen < 432) begin
      waitCycles(stopLen);
      rx = 1'b1;
      waitCycles(432 - stopLen);
    end else begin
      waitCycles(432);
    end
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input int idx);
    int    feBefore;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (vecs[idx].clrBefore) clearAndCheck(tag);
    if (vecs[idx].glitch) begin
      feBefore = feCount;
      alignToTick();
      rx = 1'b0;
      waitCycles(81);
      rx = 1'b1;
      waitCycles(432);
      checkOutput({tag, "_glitch_rdy"}, {7'd0, rdy}, 8'h00);
      checkOutput({tag, "_glitch_fe"}, 8'(feCount - feBefore), 8'h00);
    end
    feBefore = feCount;
    sendFrame(vecs[idx].value, vecs[idx].stopVal, vecs[idx].stopVal ? 432 : 300,
              vecs[idx].clrAtDone);
    checkOutput({tag, "_data"}, data, vecs[idx].expData);
    checkOutput({tag, "_rdy"}, {7'd0, rdy}, {7'd0, vecs[idx].expRdy});
    checkOutput({tag, "_ovr"}, {7'd0, overrun}, {7'd0, vecs[idx].expOvr});
    checkOutput({tag, "_fe_pulses"}, 8'(feCount - feBefore), 8'(vecs[idx].expFe));
  endtask

  initial begin
    //          value  stop glit clrB clrD  data   rdy   ovr   fe
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};

    rst     = 1'b1;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    waitCycles(5);
    rst = 1'b0;
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_rdy", {7'd0, rdy}, 8'h00);
    checkOutput("reset_fe", {7'd0, frame_err}, 8'h00);
    checkOutput("reset_ovr", {7'd0, overrun}, 8'h00);
    waitCycles(20);

    for (int i = 0; i < 6; i++) applyStimulus(i);

    // Reset in the middle of data bit 4 of a 0x00 frame.
    alignToTick();
    rx = 1'b0;
    waitCycles(432 * 5 + 200);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    checkOutput("midrst_data", data, 8'h00);
    checkOutput("midrst_rdy", {7'd0, rdy}, 8'h00);
    checkOutput("midrst_fe", {7'd0, frame_err}, 8'h00);
    checkOutput("midrst_ovr", {7'd0, overrun}, 8'h00);
    waitCycles(432 * 3 - 202);
    rx = 1'b1;
    waitCycles(432 * 12);
    clearAndCheck("midrst");
    sendFrame(8'h5A, 1'b1, 432, 1'b0);
    checkOutput("resync_data", data, 8'h5A);
    checkOutput("resync_rdy", {7'd0, rdy}, 8'h01);
    checkOutput("resync_ovr", {7'd0, overrun}, 8'h00);

    checkOutput("fe_width", 8'(feMaxRun), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 frames, sampled with the 16x-oversampling `rxclk_en` strobe from the baud rate generator (115200 baud from `clk_50m`). It synchronises the asynchronous serial input and rejects start-bit glitches. Each frame is sampled at mid-bit, and the byte is presented with a ready flag that the consumer clears. It sits between the board RX pin and the host-side logic, opposite the UART transmitter.

## Interface
- No parameters: frame format fixed at 1 start, 8 data LSB-first, 1 stop, no parity; oversampling fixed at 16.
- `clk_50m`  in  1  system clock, 50 MHz; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clken`  in  1  one-cycle strobe at 16x baud; connect to `rxclk_en`.
- `rx`  in  1  asynchronous serial line; idles high.
- `rdy_clr`  in  1  consumer acknowledge; clears `rdy` and `overrun`.
- `data`  out  8  last correctly framed byte.
- `rdy`  out  1  byte available in `data`; sticky until `rdy_clr`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  sticky; a byte completed while `rdy` was still 1.

## Operation
- **Synchroniser:** two flops `rx` -> `rx_s`, both reset to 1. All decisions use `rx_s`.
- **Counters:** 4-bit `sample` counts `clken` ticks. 3-bit `bitidx` selects the data bit. 8-bit `scratch` is the assembly register.
- State and counter updates occur only on cycles with `clken`=1, except reset and `rdy_clr` handling.
- **IDLE:** on `clken` with `rx_s`=0, go to START with `sample`=1.
- **START:**
  - On `clken` with `rx_s`=1: return to IDLE (glitch; no output changes).
  - On `clken` with `rx_s`=0 and `sample`=7: go to DATA with `sample`=0, `bitidx`=0 (mid start bit, 8 low ticks).
  - Otherwise: `sample`+1.
- **DATA:** on `clken`:
  - If `sample`=15: `scratch[bitidx]`<=`rx_s`, `sample`=0. If `bitidx`=7, go to STOP; else `bitidx`+1.
  - Otherwise: `sample`+1.
- **STOP:** on `clken`:
  - If `sample`=15 and `rx_s`=1: `data`<=`scratch`, `rdy`<=1, `overrun`<=`rdy` (old value) OR `overrun`; go to IDLE with `sample`=0.
  - If `sample`=15 and `rx_s`=0: `frame_err`<=1 for one cycle; `data`, `rdy`, `overrun` unchanged; go to IDLE.
  - Otherwise: `sample`+1.
- Returning to IDLE at mid-stop-bit allows back-to-back frames.
- `rdy_clr`=1 clears `rdy` and `overrun` on the next edge. If a byte completes in the same cycle, set wins: `rdy`=1, and `overrun` takes the set-side value.
- **Counter widths:** `sample` and `bitidx` never wrap outside the transitions above. No other arithmetic.

## Timing
- **Reset values:** state IDLE; `data`=8'h00; `rdy`=0; `frame_err`=0; `overrun`=0; `sample`=0; `bitidx`=0; `scratch`=0; sync flops=1.
- **Reset mid-frame:** abandons the frame with no output pulse.
  - Trailing low data bits after reset may be taken as a start bit; this is accepted behaviour.
  - The receiver resynchronises after one idle-high bit time.
- `rx` to `rx_s` latency: 2 cycles.
- Mid-bit samples fall 8 + 16k ticks after the first low tick. With `clken` every 27 cycles, one bit is 432 cycles.
- `rdy` / `data` / `frame_err` update one cycle after the `clken` cycle that samples the stop bit, about 152 ticks after start detection.
- `frame_err` is high for exactly one clock.
- `clken` held low freezes all state; outputs hold.

## Test plan
- **Single byte:** reset, then drive 0xA5 as 8N1 with 432-cycle bits, `clken` every 27 cycles -> `data`=8'hA5, `rdy`=1, `frame_err`=0, `overrun`=0. Then `rdy_clr` pulse -> `rdy`=0 next cycle.
- **Glitch:** `rx` low for 3 ticks then high -> state returns to IDLE, `rdy` stays 0; a following 0x3C frame is received correctly.
- **Framing error:** 0x3C with stop bit 0 -> one-cycle `frame_err`, `rdy`=0, `data` keeps previous 8'hA5.
- **Overrun:** 0x11 then 0x22 back-to-back, no `rdy_clr` -> `data`=8'h22, `rdy`=1, `overrun`=1. `rdy_clr` clears both.
- **Clear/set collision:** assert `rdy_clr` in the completion cycle of 0xFF with `rdy` previously 0 -> `rdy`=1, `data`=8'hFF, `overrun`=0.
- **Reset mid-frame:** assert `rst` during bit 4 of 0x00 -> all outputs at reset values. After line idle ≥ 1 bit time, 0x5A is received correctly.
